// File: rtl/input_capture_buffer.sv
// Input capture stage: masks and latches a WIDTH-bit sample on an enable strobe,
// keeps the latest word on hold_out and queues every capture in a small FIFO.
module input_capture_buffer #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] INV_MASK  = '1,
  parameter logic [WIDTH-1:0] HOLD_RST  = '1,
  parameter bit               EDGE_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           hold_out,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             en_d;
  logic             cap;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic [WIDTH-1:0] word;

  // Read port handshake: a word transfers on every clock edge where
  // out_valid and out_ready are both high; out_data is stable while
  // out_valid is high and out_ready is low.
  assign cap      = EDGE_MODE ? (en & ~en_d) : en;
  assign word     = data_in ^ INV_MASK;
  assign pop      = out_valid & out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = cap & (~full | pop);
  assign drop     = cap & ~push_ok;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      en_d     <= 1'b0;
      hold_out <= HOLD_RST;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      en_d <= en;
      if (cap) hold_out <= word;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped capture beats a clear issued on the same cycle.
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= word;
  end

endmodule
